mesh_network_interface: RTL and testbench

// - Network interface (NI) between one processing core and the LOCAL port of a mesh router.
// - Injection path: the core supplies a message and destination (x,y). The NI packs the destination address, buffers the message and drives the router local input.
// - Ejection path: buffers packets leaving the router local output, checks that each one was delivered to this node, and presents them to the core.
// - Keeps per-node traffic counters and a sticky misroute error.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/noc_sync_fifo.sv | 48 ++++
 rtl/mesh_network_interface.sv | 135 +++++++++++++
 tb/tb_mesh_network_interface.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh NoC port indices and address pack/unpack helpers
package noc_pkg;

  localparam int NORTH     = 0;
  localparam int EAST      = 1;
  localparam int SOUTH     = 2;
  localparam int WEST      = 3;
  localparam int LOCAL     = 4;
  localparam int NUM_PORTS = 5;

  // X occupies the top xw bits, Y the next yw bits, the rest is zero.
  function automatic logic [31:0] pack_addr(input logic [31:0] x, input logic [31:0] y,
                                            input int xw, input int yw, input int aw);
    logic [31:0] mask_x;
    logic [31:0] mask_y;
    mask_x = (32'd1 << xw) - 32'd1;
    mask_y = (32'd1 << yw) - 32'd1;
    return ((x & mask_x) << (aw - xw)) | ((y & mask_y) << (aw - xw - yw));
  endfunction

  function automatic logic [31:0] unpack_x(input logic [31:0] addr, input int xw, input int aw);
    logic [31:0] mask_x;
    mask_x = (32'd1 << xw) - 32'd1;
    return (addr >> (aw - xw)) & mask_x;
  endfunction

  function automatic logic [31:0] unpack_y(input logic [31:0] addr, input int xw, input int yw,
                                           input int aw);
    logic [31:0] mask_y;
    mask_y = (32'd1 << yw) - 32'd1;
    return (addr >> (aw - xw - yw)) & mask_y;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - single-clock FIFO with registered storage and zeroed head when empty
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/mesh_network_interface.sv
// rtl/mesh_network_interface.sv - NI between a core and the router LOCAL port
// Injection/ejection FIFOs, delivery address check, saturating traffic counters.
module mesh_network_interface
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int INJ_DEPTH    = 4,
  parameter int EJ_DEPTH     = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [X_ADDR_WIDTH-1:0] local_x_addr,
  input  logic [Y_ADDR_WIDTH-1:0] local_y_addr,
  input  logic                    inj_valid_i,
  input  logic [DATA_WIDTH-1:0]   inj_data_i,
  input  logic [X_ADDR_WIDTH-1:0] inj_dest_x_i,
  input  logic [Y_ADDR_WIDTH-1:0] inj_dest_y_i,
  output logic                    inj_ready_o,
  output logic                    rtr_valid_o,
  output logic [DATA_WIDTH-1:0]   rtr_data_o,
  output logic [ADDR_WIDTH-1:0]   rtr_addr_o,
  input  logic                    rtr_ready_i,
  input  logic                    rtr_valid_i,
  input  logic [DATA_WIDTH-1:0]   rtr_data_i,
  input  logic [ADDR_WIDTH-1:0]   rtr_addr_i,
  output logic                    rtr_ready_o,
  output logic                    ej_valid_o,
  output logic [DATA_WIDTH-1:0]   ej_data_o,
  input  logic                    ej_ready_i,
  input  logic                    cnt_clr_i,
  output logic [CNT_WIDTH-1:0]    inj_cnt_o,
  output logic [CNT_WIDTH-1:0]    ej_cnt_o,
  output logic [CNT_WIDTH-1:0]    drop_cnt_o,
  output logic                    misroute_err_o
);

  logic [ADDR_WIDTH-1:0]            w_inj_addr;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_inj_head;
  logic                             w_inj_full;
  logic                             w_inj_empty;
  logic                             w_inj_push;
  logic                             w_inj_pop;
  logic                             w_ej_full;
  logic                             w_ej_empty;
  logic                             w_ej_accept;
  logic                             w_is_local;
  logic                             w_ej_push;
  logic                             w_ej_pop;
  logic                             w_drop;
  logic [CNT_WIDTH-1:0]             r_inj_cnt;
  logic [CNT_WIDTH-1:0]             r_ej_cnt;
  logic [CNT_WIDTH-1:0]             r_drop_cnt;
  logic                             r_misroute_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign w_inj_addr = ADDR_WIDTH'(pack_addr(32'(inj_dest_x_i), 32'(inj_dest_y_i),
                                            X_ADDR_WIDTH, Y_ADDR_WIDTH, ADDR_WIDTH));

  assign inj_ready_o = !w_inj_full;
  assign w_inj_push  = inj_valid_i && inj_ready_o;
  assign rtr_valid_o = !w_inj_empty;
  assign w_inj_pop   = rtr_valid_o && rtr_ready_i;
  assign {rtr_addr_o, rtr_data_o} = w_inj_head;

  noc_sync_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_inj_push),
    .i_data  ({w_inj_addr, inj_data_i}),
    .i_pop   (w_inj_pop),
    .o_data  (w_inj_head),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty)
  );

  // A misrouted packet is still consumed, but only when there is room to accept.
  assign rtr_ready_o = !w_ej_full;
  assign w_ej_accept = rtr_valid_i && rtr_ready_o;
  assign w_is_local  = (unpack_x(32'(rtr_addr_i), X_ADDR_WIDTH, ADDR_WIDTH) == 32'(local_x_addr)) &&
                       (unpack_y(32'(rtr_addr_i), X_ADDR_WIDTH, Y_ADDR_WIDTH, ADDR_WIDTH) ==
                        32'(local_y_addr));
  assign w_ej_push   = w_ej_accept && w_is_local;
  assign w_drop      = w_ej_accept && !w_is_local;
  assign ej_valid_o  = !w_ej_empty;
  assign w_ej_pop    = ej_valid_o && ej_ready_i;

  noc_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_ej_push),
    .i_data  (rtr_data_i),
    .i_pop   (w_ej_pop),
    .o_data  (ej_data_o),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inj_cnt      <= '0;
      r_ej_cnt       <= '0;
      r_drop_cnt     <= '0;
      r_misroute_err <= 1'b0;
    end else if (cnt_clr_i) begin
      r_inj_cnt      <= '0;
      r_ej_cnt       <= '0;
      r_drop_cnt     <= '0;
      r_misroute_err <= 1'b0;
    end else begin
      r_inj_cnt      <= sat_inc(r_inj_cnt, w_inj_pop);
      r_ej_cnt       <= sat_inc(r_ej_cnt, w_ej_pop);
      r_drop_cnt     <= sat_inc(r_drop_cnt, w_drop);
      r_misroute_err <= r_misroute_err | w_drop;
    end
  end

  assign inj_cnt_o      = r_inj_cnt;
  assign ej_cnt_o       = r_ej_cnt;
  assign drop_cnt_o     = r_drop_cnt;
  assign misroute_err_o = r_misroute_err;

endmodule

// File: tb/tb_mesh_network_interface.sv
// tb/tb_mesh_network_interface.sv - randomized bench with a queue-based reference model
module tb_mesh_network_interface;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int INJD = 4;
  localparam int EJD  = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] local_x_addr;
  logic [YW-1:0] local_y_addr;
  logic          inj_valid_i;
  logic [DW-1:0] inj_data_i;
  logic [XW-1:0] inj_dest_x_i;
  logic [YW-1:0] inj_dest_y_i;
  logic          inj_ready_o;
  logic          rtr_valid_o;
  logic [DW-1:0] rtr_data_o;
  logic [AW-1:0] rtr_addr_o;
  logic          rtr_ready_i;
  logic          rtr_valid_i;
  logic [DW-1:0] rtr_data_i;
  logic [AW-1:0] rtr_addr_i;
  logic          rtr_ready_o;
  logic          ej_valid_o;
  logic [DW-1:0] ej_data_o;
  logic          ej_ready_i;
  logic          cnt_clr_i;
  logic [CW-1:0] inj_cnt_o;
  logic [CW-1:0] ej_cnt_o;
  logic [CW-1:0] drop_cnt_o;
  logic          misroute_err_o;

  mesh_network_interface #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW),
    .INJ_DEPTH(INJD), .EJ_DEPTH(EJD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .local_x_addr(local_x_addr), .local_y_addr(local_y_addr),
    .inj_valid_i(inj_valid_i), .inj_data_i(inj_data_i), .inj_dest_x_i(inj_dest_x_i),
    .inj_dest_y_i(inj_dest_y_i), .inj_ready_o(inj_ready_o), .rtr_valid_o(rtr_valid_o),
    .rtr_data_o(rtr_data_o), .rtr_addr_o(rtr_addr_o), .rtr_ready_i(rtr_ready_i),
    .rtr_valid_i(rtr_valid_i), .rtr_data_i(rtr_data_i), .rtr_addr_i(rtr_addr_i),
    .rtr_ready_o(rtr_ready_o), .ej_valid_o(ej_valid_o), .ej_data_o(ej_data_o),
    .ej_ready_i(ej_ready_i), .cnt_clr_i(cnt_clr_i), .inj_cnt_o(inj_cnt_o),
    .ej_cnt_o(ej_cnt_o), .drop_cnt_o(drop_cnt_o), .misroute_err_o(misroute_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and integer counters.
  logic [AW+DW-1:0] m_inj_q[$];
  logic [DW-1:0]    m_ej_q[$];
  int               m_inj_cnt, m_ej_cnt, m_drop_cnt;
  bit               m_err;

  function automatic logic [AW-1:0] m_pack(input int x, input int y);
    int a;
    a = x * (2 ** (AW - XW)) + y * (2 ** (AW - XW - YW));
    return a[AW-1:0];
  endfunction

  function automatic bit m_is_local(input int a);
    return ((a / (2 ** (AW - XW))) == int'(local_x_addr)) &&
           (((a / (2 ** (AW - XW - YW))) % (2 ** YW)) == int'(local_y_addr));
  endfunction

  function automatic int m_sat(input int v, input bit ev);
    return (ev && v < CMAX) ? v + 1 : v;
  endfunction

  always @(negedge clk) begin
    bit inj_pop, inj_push, ej_pop, ej_acc;
    if (rst) begin
      m_inj_q.delete();
      m_ej_q.delete();
      m_inj_cnt = 0; m_ej_cnt = 0; m_drop_cnt = 0; m_err = 0;
    end else begin
      check("rtr_valid", rtr_valid_o, m_inj_q.size() != 0);
      check("rtr_head", {rtr_addr_o, rtr_data_o}, m_inj_q.size() != 0 ? m_inj_q[0] : '0);
      check("inj_ready", inj_ready_o, m_inj_q.size() < INJD);
      check("ej_valid", ej_valid_o, m_ej_q.size() != 0);
      check("ej_data", ej_data_o, m_ej_q.size() != 0 ? m_ej_q[0] : '0);
      check("rtr_ready", rtr_ready_o, m_ej_q.size() < EJD);
      check("inj_cnt", inj_cnt_o, m_inj_cnt);
      check("ej_cnt", ej_cnt_o, m_ej_cnt);
      check("drop_cnt", drop_cnt_o, m_drop_cnt);
      check("misroute_err", misroute_err_o, m_err);

      inj_pop  = m_inj_q.size() > 0 && rtr_ready_i;
      inj_push = inj_valid_i && m_inj_q.size() < INJD;
      ej_pop   = m_ej_q.size() > 0 && ej_ready_i;
      ej_acc   = rtr_valid_i && m_ej_q.size() < EJD;
      if (inj_pop) void'(m_inj_q.pop_front());
      if (inj_push) m_inj_q.push_back({m_pack(inj_dest_x_i, inj_dest_y_i), inj_data_i});
      if (ej_pop) void'(m_ej_q.pop_front());
      if (ej_acc && m_is_local(rtr_addr_i)) m_ej_q.push_back(rtr_data_i);
      if (cnt_clr_i) begin
        m_inj_cnt = 0; m_ej_cnt = 0; m_drop_cnt = 0; m_err = 0;
      end else begin
        m_inj_cnt  = m_sat(m_inj_cnt, inj_pop);
        m_ej_cnt   = m_sat(m_ej_cnt, ej_pop);
        m_drop_cnt = m_sat(m_drop_cnt, ej_acc && !m_is_local(rtr_addr_i));
        if (ej_acc && !m_is_local(rtr_addr_i)) m_err = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inj_valid_i = 0; inj_data_i = '0; inj_dest_x_i = '0; inj_dest_y_i = '0;
    rtr_ready_i = 0; rtr_valid_i = 0; rtr_data_i = '0; rtr_addr_i = '0;
    ej_ready_i = 0; cnt_clr_i = 0;
  endtask

  initial begin
    rst = 1;
    local_x_addr = 4'd1;
    local_y_addr = 4'd2;
    idle();
    repeat (3) tick();
    check("rst_rtr_valid", rtr_valid_o, 0);
    check("rst_ej_valid", ej_valid_o, 0);
    check("rst_rtr_data", {rtr_addr_o, rtr_data_o}, 0);
    check("rst_ej_data", ej_data_o, 0);
    check("rst_counters", {inj_cnt_o, ej_cnt_o, drop_cnt_o, misroute_err_o}, 0);
    rst = 0;
    #1;
    check("rst_readies", {inj_ready_o, rtr_ready_o}, 2'b11);

    // Single injection to (3,1).
    inj_valid_i = 1; inj_data_i = 32'hA5A5_0001; inj_dest_x_i = 4'd3; inj_dest_y_i = 4'd1;
    rtr_ready_i = 1;
    tick();
    inj_valid_i = 0;
    check("inj1_valid", rtr_valid_o, 1);
    check("inj1_addr", rtr_addr_o, 8'h31);
    check("inj1_data", rtr_data_o, 32'hA5A5_0001);
    tick();
    check("inj1_cnt", inj_cnt_o, 1);

    // Fill the injection FIFO with the router stalled, then drain in order.
    rtr_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      inj_valid_i = 1; inj_data_i = 100 + i; inj_dest_x_i = 4'(i); inj_dest_y_i = 4'(i + 1);
      tick();
    end
    inj_valid_i = 0;
    check("inj_full_ready", inj_ready_o, 0);
    rtr_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      check("inj_order", rtr_data_o, 100 + i);
      tick();
    end
    rtr_ready_i = 0;
    check("inj_drained", rtr_valid_o, 0);

    // Local delivery then a misrouted packet.
    rtr_valid_i = 1; rtr_addr_i = 8'h12; rtr_data_i = 32'hDEAD_0001;
    tick();
    rtr_valid_i = 0;
    check("ej_local_valid", ej_valid_o, 1);
    check("ej_local_data", ej_data_o, 32'hDEAD_0001);
    rtr_valid_i = 1; rtr_addr_i = 8'h22; rtr_data_i = 32'hBAD0_0002;
    tick();
    rtr_valid_i = 0;
    check("drop_cnt1", drop_cnt_o, 1);
    check("misroute1", misroute_err_o, 1);
    ej_ready_i = 1;
    tick();
    ej_ready_i = 0;
    check("ej_cnt1", ej_cnt_o, 1);

    // Fill ejection FIFO; pop while the router keeps offering.
    for (int i = 0; i < 4; i++) begin
      rtr_valid_i = 1; rtr_addr_i = 8'h12; rtr_data_i = 200 + i;
      tick();
    end
    rtr_valid_i = 0;
    check("ej_full_ready", rtr_ready_o, 0);
    rtr_valid_i = 1; rtr_data_i = 300; ej_ready_i = 1;
    tick();
    tick();
    rtr_valid_i = 0;
    check("ej_after0", ej_data_o, 202);
    tick();
    check("ej_after1", ej_data_o, 203);
    tick();
    check("ej_after2", ej_data_o, 300);
    tick();
    ej_ready_i = 0;
    check("ej_drained", ej_valid_o, 0);

    // Saturation of the injection counter, then clear racing an event.
    cnt_clr_i = 1;
    tick();
    cnt_clr_i = 0;
    rtr_ready_i = 1; inj_valid_i = 1;
    for (int i = 0; i < CMAX + 5; i++) begin
      inj_data_i = $urandom; inj_dest_x_i = 4'($urandom_range(0, 15));
      inj_dest_y_i = 4'($urandom_range(0, 15));
      tick();
    end
    inj_valid_i = 0;
    tick();
    tick();
    check("inj_cnt_sat", inj_cnt_o, CMAX);
    inj_valid_i = 1; inj_data_i = 32'h1234_5678;
    tick();
    inj_valid_i = 0; cnt_clr_i = 1;
    tick();
    cnt_clr_i = 0;
    check("clr_wins", inj_cnt_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      inj_valid_i  = ($urandom_range(0, 1) == 1);
      inj_data_i   = $urandom;
      inj_dest_x_i = 4'($urandom_range(0, 15));
      inj_dest_y_i = 4'($urandom_range(0, 15));
      rtr_ready_i  = ($urandom_range(0, 9) < 6);
      rtr_valid_i  = ($urandom_range(0, 1) == 1);
      rtr_data_i   = $urandom;
      rtr_addr_i   = ($urandom_range(0, 9) < 7) ? 8'h12 : 8'($urandom_range(0, 255));
      ej_ready_i   = ($urandom_range(0, 9) < 5);
      cnt_clr_i    = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    tick();

    // Reset with two entries in each FIFO.
    for (int i = 0; i < 2; i++) begin
      inj_valid_i = 1; inj_data_i = 500 + i; inj_dest_x_i = 4'd2; inj_dest_y_i = 4'd2;
      rtr_valid_i = 1; rtr_addr_i = 8'h12; rtr_data_i = 600 + i;
      tick();
    end
    idle();
    rst = 1;
    #1;
    check("midrst_valids", {rtr_valid_o, ej_valid_o}, 2'b00);
    check("midrst_data", {rtr_data_o, ej_data_o}, 0);
    tick();
    tick();
    rst = 0;
    #1;
    check("postrst_valids", {rtr_valid_o, ej_valid_o}, 2'b00);
    check("postrst_readies", {inj_ready_o, rtr_ready_o}, 2'b11);
    check("postrst_counters", {inj_cnt_o, ej_cnt_o, drop_cnt_o, misroute_err_o}, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
